// File: rtl/lock_pkg.sv
// Shared types for the digital-lock controller: FSM states, key decode helper
// and bench-scale timing constants.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        UNLOCKED,
        LOCKOUT,
        PROGRAM
    } state_t;

    localparam int MAX_BTNS = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } key_t;

    localparam int SIM_LOCKOUT_CYC  = 20;
    localparam int SIM_UNLOCK_CYC   = 30;
    localparam int SIM_ENTRY_TO_CYC = 15;

    // valid only when exactly one bit is set; idx is then that bit's position
    function automatic key_t onehot_to_idx(input logic [MAX_BTNS-1:0] vec);
        key_t k;
        int   hits;
        k    = '0;
        hits = 0;
        for (int i = 0; i < MAX_BTNS; i++) begin
            if (vec[i]) begin
                hits  = hits + 1;
                k.idx = 5'(i);
            end
        end
        k.valid = (hits == 1);
        return k;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by every timeout of the lock controller;
// expired is high while the count sits at zero.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/digital_lock_ctrl.sv
// Keypad code-entry sequencer with failed-attempt lockout, entry timeout and auto relock.
// Define LOCK_PROGRAM_EN to allow reprogramming the stored code while unlocked.
module digital_lock_ctrl
    import lock_pkg::*;
#(
    parameter int NUM_BTNS     = 4,
    parameter int CODE_LEN     = 4,
    parameter logic [CODE_LEN*$clog2(NUM_BTNS)-1:0] DEFAULT_CODE = {2'd3, 2'd2, 2'd1, 2'd0},
    parameter int MAX_FAIL     = 3,
    parameter int LOCKOUT_CYC  = 125_000_000,
    parameter int UNLOCK_CYC   = 625_000_000,
    parameter int ENTRY_TO_CYC = 375_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_BTNS-1:0]           btn_pulse,
    input  logic                          prog,
    output logic                          locked,
    output logic                          unlocked,
    output logic                          lockout,
    output logic                          err,
    output logic [$clog2(CODE_LEN+1)-1:0] digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output state_t                        fsm_state
);

    localparam int DW      = $clog2(NUM_BTNS);
    localparam int CW      = CODE_LEN * DW;
    localparam int DCW     = $clog2(CODE_LEN + 1);
    localparam int FCW     = $clog2(MAX_FAIL + 1);
    localparam int MAX_LU  = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int MAX_CYC = (MAX_LU > ENTRY_TO_CYC) ? MAX_LU : ENTRY_TO_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    state_t         state, state_n;
    logic [DCW-1:0] digit_cnt_n;
    logic [FCW-1:0] fail_cnt_n;
    logic           mism, mism_n, err_n;
    logic [CW-1:0]  code;
    key_t           key;
    logic [DW-1:0]  digit;
    logic           any_key, digit_hit, last_digit;
    logic           timer_load, expired;
    logic [TW-1:0]  timer_val;
    logic           unused_bits;

    assign key        = onehot_to_idx(MAX_BTNS'(btn_pulse));
    assign digit      = key.idx[DW-1:0];
    assign any_key    = |btn_pulse;
    assign digit_hit  = key.valid && (digit == code[int'(digit_cnt)*DW +: DW]);
    assign last_digit = (digit_cnt == DCW'(CODE_LEN - 1));
    assign unused_bits = ^{prog, key.idx};

`ifdef LOCK_PROGRAM_EN
    logic [CW-1:0] code_q, code_n, shadow, shadow_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q <= DEFAULT_CODE;
            shadow <= '0;
        end else begin
            code_q <= code_n;
            shadow <= shadow_n;
        end
    end

    assign code = code_q;
`else
    assign code = DEFAULT_CODE;
`endif

    always_comb begin
        state_n     = state;
        digit_cnt_n = digit_cnt;
        fail_cnt_n  = fail_cnt;
        mism_n      = mism;
        err_n       = 1'b0;
`ifdef LOCK_PROGRAM_EN
        shadow_n    = shadow;
        code_n      = code_q;
`endif
        case (state)
            IDLE, ENTRY: begin
                if (any_key) begin
                    // an invalid key still consumes a digit slot but poisons the attempt
                    err_n       = !key.valid;
                    mism_n      = ((state == ENTRY) && mism) || !digit_hit;
                    digit_cnt_n = digit_cnt + 1'b1;
                    state_n     = last_digit ? CHECK : ENTRY;
                end else if ((state == ENTRY) && expired) begin
                    err_n       = 1'b1;
                    digit_cnt_n = '0;
                    state_n     = IDLE;
                end
            end
            CHECK: begin
                digit_cnt_n = '0;
                if (!mism) begin
                    fail_cnt_n = '0;
                    state_n    = UNLOCKED;
                end else begin
                    err_n = 1'b1;
                    if (fail_cnt != FCW'(MAX_FAIL)) fail_cnt_n = fail_cnt + 1'b1;
                    state_n = (fail_cnt_n == FCW'(MAX_FAIL)) ? LOCKOUT : IDLE;
                end
            end
            UNLOCKED: begin
                if (any_key) begin
                    state_n = IDLE;
`ifdef LOCK_PROGRAM_EN
                    if (prog) state_n = PROGRAM;
`endif
                end else if (expired) begin
                    state_n = IDLE;
                end
            end
            LOCKOUT: begin
                if (expired) begin
                    fail_cnt_n = '0;
                    state_n    = IDLE;
                end
            end
`ifdef LOCK_PROGRAM_EN
            PROGRAM: begin
                if (any_key && key.valid) begin
                    shadow_n[int'(digit_cnt)*DW +: DW] = digit;
                    digit_cnt_n = digit_cnt + 1'b1;
                    if (last_digit) begin
                        code_n      = shadow_n;
                        digit_cnt_n = '0;
                        state_n     = IDLE;
                    end
                end else if (any_key || expired) begin
                    err_n       = 1'b1;
                    digit_cnt_n = '0;
                    state_n     = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // the timer restarts on every state change and on every digit accepted mid-sequence
    assign timer_load = (state_n != state) || (any_key && ((state == ENTRY) || (state == PROGRAM)));

    always_comb begin
        case (state_n)
            ENTRY, PROGRAM: timer_val = TW'(ENTRY_TO_CYC - 1);
            UNLOCKED:       timer_val = TW'(UNLOCK_CYC - 1);
            LOCKOUT:        timer_val = TW'(LOCKOUT_CYC - 1);
            default:        timer_val = '0;
        endcase
    end

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            digit_cnt <= '0;
            fail_cnt  <= '0;
            mism      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            digit_cnt <= digit_cnt_n;
            fail_cnt  <= fail_cnt_n;
            mism      <= mism_n;
            err       <= err_n;
        end
    end

    assign locked    = (state == IDLE) || (state == ENTRY) || (state == CHECK);
    assign unlocked  = (state == UNLOCKED) || (state == PROGRAM);
    assign lockout   = (state == LOCKOUT);
    assign fsm_state = state;

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// Bench for digital_lock_ctrl: directed scenarios plus randomized key traffic
// checked every cycle against a behavioural model of the lock.
module tb_digital_lock_ctrl;
    import lock_pkg::*;

    localparam int NUM_BTNS     = 4;
    localparam int CODE_LEN     = 4;
    localparam int MAX_FAIL     = 3;
    localparam int LOCKOUT_CYC  = 20;
    localparam int UNLOCK_CYC   = 30;
    localparam int ENTRY_TO_CYC = 15;
`ifdef LOCK_PROGRAM_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    localparam int M_LOCKED  = 0;
    localparam int M_CHECK   = 1;
    localparam int M_OPEN    = 2;
    localparam int M_BLOCKED = 3;
    localparam int M_PROG    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       prog = 1'b0;
    logic       locked, unlocked, lockout, err;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;
    state_t     fsm_state;
    bit         checking = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    digital_lock_ctrl #(
        .NUM_BTNS(NUM_BTNS), .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL),
        .LOCKOUT_CYC(LOCKOUT_CYC), .UNLOCK_CYC(UNLOCK_CYC), .ENTRY_TO_CYC(ENTRY_TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .btn_pulse(btn), .prog(prog),
        .locked(locked), .unlocked(unlocked), .lockout(lockout), .err(err),
        .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_mode = M_LOCKED;
    int m_digits[$];
    int m_fails = 0;
    int m_elapsed = 0;
    bit m_err = 1'b0;
    int m_code[CODE_LEN] = '{0, 1, 2, 3};

    function automatic void model_reset();
        m_mode    = M_LOCKED;
        m_digits.delete();
        m_fails   = 0;
        m_elapsed = 0;
        m_err     = 1'b0;
        m_code    = '{0, 1, 2, 3};
    endfunction

    function automatic void model_step(input logic [3:0] p, input logic pg);
        int ones, idx;
        bit ok;
        ones = 0;
        idx  = 0;
        for (int i = 0; i < NUM_BTNS; i++) if (p[i]) begin ones++; idx = i; end
        m_err = 1'b0;
        case (m_mode)
            M_LOCKED: begin
                if (ones > 0) begin
                    if (ones != 1) m_err = 1'b1;
                    m_digits.push_back((ones == 1) ? idx : -1);
                    m_elapsed = 0;
                    if (m_digits.size() == CODE_LEN) m_mode = M_CHECK;
                end else if (m_digits.size() > 0) begin
                    m_elapsed++;
                    if (m_elapsed == ENTRY_TO_CYC) begin m_err = 1'b1; m_digits.delete(); end
                end
            end
            M_CHECK: begin
                ok = 1'b1;
                for (int i = 0; i < CODE_LEN; i++) if (m_digits[i] != m_code[i]) ok = 1'b0;
                m_digits.delete();
                m_elapsed = 0;
                if (ok) begin
                    m_fails = 0;
                    m_mode  = M_OPEN;
                end else begin
                    m_err = 1'b1;
                    if (m_fails < MAX_FAIL) m_fails++;
                    m_mode = (m_fails == MAX_FAIL) ? M_BLOCKED : M_LOCKED;
                end
            end
            M_OPEN: begin
                if (ones > 0) begin
                    m_mode = (PROG_EN && pg) ? M_PROG : M_LOCKED;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == UNLOCK_CYC) m_mode = M_LOCKED;
                end
            end
            M_BLOCKED: begin
                m_elapsed++;
                if (m_elapsed == LOCKOUT_CYC) begin m_fails = 0; m_mode = M_LOCKED; end
            end
            default: begin
                if (ones > 1) begin
                    m_err = 1'b1; m_digits.delete(); m_mode = M_LOCKED;
                end else if (ones == 1) begin
                    m_digits.push_back(idx);
                    m_elapsed = 0;
                    if (m_digits.size() == CODE_LEN) begin
                        for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_digits[i];
                        m_digits.delete();
                        m_mode = M_LOCKED;
                    end
                end else begin
                    m_elapsed++;
                    if (m_elapsed == ENTRY_TO_CYC) begin m_err = 1'b1; m_digits.delete(); m_mode = M_LOCKED; end
                end
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step(btn, prog);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (checking) begin
            check("model_locked",    32'(locked),    32'(m_mode == M_LOCKED || m_mode == M_CHECK));
            check("model_unlocked",  32'(unlocked),  32'(m_mode == M_OPEN || m_mode == M_PROG));
            check("model_lockout",   32'(lockout),   32'(m_mode == M_BLOCKED));
            check("model_err",       32'(err),       32'(m_err));
            check("model_digit_cnt", 32'(digit_cnt), 32'(m_digits.size()));
            check("model_fail_cnt",  32'(fail_cnt),  32'(m_fails));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clk);
        btn = v;
        @(negedge clk);
        btn = 4'b0;
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d, input int gap);
        int ds[4];
        ds = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            press(4'b0001 << ds[i]);
            if (i < 3) idle(gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int kind;
        logic [3:0] v;
        repeat (3) @(negedge clk);
        check("reset_locked",    32'(locked),    32'd1);
        check("reset_unlocked",  32'(unlocked),  32'd0);
        check("reset_lockout",   32'(lockout),   32'd0);
        check("reset_err",       32'(err),       32'd0);
        check("reset_digit_cnt", 32'(digit_cnt), 32'd0);
        check("reset_fail_cnt",  32'(fail_cnt),  32'd0);
        rst = 1'b1;
        checking = 1'b1;

        // correct code, four cycles apart
        enter4(0, 1, 2, 3, 2);
        check("open_after_1_edge", 32'(unlocked), 32'd0);
        check("check_digit_cnt",   32'(digit_cnt), 32'd4);
        @(negedge clk);
        check("open_after_2_edges", 32'(unlocked), 32'd1);
        check("open_fail_cnt",      32'(fail_cnt), 32'd0);
        idle(29);
        check("open_last_cycle", 32'(unlocked), 32'd1);
        idle(1);
        check("auto_relock", 32'(locked), 32'd1);

        // wrong code
        enter4(0, 1, 2, 2, 2);
        check("wrong_no_err_yet", 32'(err), 32'd0);
        @(negedge clk);
        check("wrong_err",      32'(err),      32'd1);
        check("wrong_fail_cnt", 32'(fail_cnt), 32'd1);
        check("wrong_unlocked", 32'(unlocked), 32'd0);

        // two more wrong codes reach lockout
        idle(1);
        enter4(0, 1, 2, 2, 1);
        idle(2);
        enter4(3, 3, 3, 3, 1);
        @(negedge clk);
        check("lockout_set",      32'(lockout),  32'd1);
        check("lockout_fail_cnt", 32'(fail_cnt), 32'd3);
        enter4(0, 1, 2, 3, 0);
        idle(11);
        check("lockout_ignores_code", 32'(lockout), 32'd1);
        check("lockout_held_fails",   32'(fail_cnt), 32'd3);
        idle(1);
        check("lockout_over",      32'(lockout),  32'd0);
        check("lockout_fail_clr",  32'(fail_cnt), 32'd0);
        enter4(0, 1, 2, 3, 1);
        @(negedge clk);
        check("unlock_after_lockout", 32'(unlocked), 32'd1);
        press(4'b0100);
        check("key_relocks", 32'(locked), 32'd1);

        // invalid key as second digit
        press(4'b0001);
        press(4'b0011);
        check("invalid_err",       32'(err),       32'd1);
        check("invalid_digit_cnt", 32'(digit_cnt), 32'd2);
        press(4'b0100);
        press(4'b1000);
        @(negedge clk);
        check("invalid_check_err", 32'(err),      32'd1);
        check("invalid_fail_cnt",  32'(fail_cnt), 32'd1);

        // entry timeout
        press(4'b0001);
        press(4'b0010);
        idle(14);
        check("timeout_not_yet", 32'(digit_cnt), 32'd2);
        idle(1);
        check("timeout_err",       32'(err),       32'd1);
        check("timeout_digit_cnt", 32'(digit_cnt), 32'd0);
        check("timeout_fail_kept", 32'(fail_cnt),  32'd1);

        // reset mid-entry
        press(4'b0001);
        press(4'b0010);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_digit_cnt", 32'(digit_cnt), 32'd0);
        check("async_rst_locked",    32'(locked),    32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_fail_cnt", 32'(fail_cnt), 32'd0);

`ifdef LOCK_PROGRAM_EN
        enter4(0, 1, 2, 3, 1);
        @(negedge clk);
        check("prog_unlocked", 32'(unlocked), 32'd1);
        prog = 1'b1;
        press(4'b1000);
        prog = 1'b0;
        check("prog_entered", 32'(unlocked), 32'd1);
        enter4(3, 3, 1, 0, 1);
        check("prog_done_locked", 32'(locked), 32'd1);
        enter4(0, 1, 2, 3, 1);
        @(negedge clk);
        check("old_code_rejected", 32'(err), 32'd1);
        enter4(3, 3, 1, 0, 1);
        @(negedge clk);
        check("new_code_opens", 32'(unlocked), 32'd1);
        press(4'b0001);
        do_reset();
`endif

        // randomized attempts
        for (int a = 0; a < 120; a++) begin
            kind = $urandom_range(0, 3);
            for (int d = 0; d < CODE_LEN; d++) begin
                v = 4'b0001 << ((kind == 0) ? m_code[d] : int'($urandom_range(0, 3)));
                if (kind == 3 && $urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
                prog = 1'($urandom_range(0, 1));
                press(v);
                idle(($urandom_range(0, 5) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4));
            end
            idle($urandom_range(0, 35));
        end

        // dense per-cycle traffic, including keys during CHECK and lockout
        repeat (600) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 60) btn = 4'b0;
            else if (r < 90) btn = 4'b0001 << $urandom_range(0, 3);
            else btn = 4'($urandom_range(0, 15));
            prog = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        btn = 4'b0;
        prog = 1'b0;
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
